// File: rtl/spi_master.sv
// spi_master: mode-0 SPI initiator, MSB first, one DATA_WIDTH word per start/done handshake
module spi_master #(
    parameter int CLK_DIV    = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] tx_data,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  spi_clk,
    output logic                  cs_n,
    output logic                  mosi,
    input  logic                  miso
);
    localparam int DW = $clog2(CLK_DIV);
    localparam int BW = $clog2(DATA_WIDTH);
    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL} state_t;
    state_t                state;
    logic [DW-1:0]         div_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] tx_sh;
    logic [DATA_WIDTH-1:0] rx_sh;
    logic                  phase_end;
    assign phase_end = div_cnt == DW'(CLK_DIV - 1);
    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            div_cnt <= '0;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            rx_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            spi_clk <= 1'b0;
            cs_n    <= 1'b1;
            mosi    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE)
                div_cnt <= phase_end ? '0 : div_cnt + 1'b1;
            case (state)
                IDLE: if (start) begin
                    tx_sh   <= tx_data;
                    mosi    <= tx_data[DATA_WIDTH-1];
                    cs_n    <= 1'b0;
                    busy    <= 1'b1;
                    bit_cnt <= '0;
                    div_cnt <= '0;
                    state   <= LEAD;
                end
                LEAD, LOW: if (phase_end) begin
                    spi_clk <= 1'b1;
                    rx_sh   <= {rx_sh[DATA_WIDTH-2:0], miso};
                    state   <= HIGH;
                end
                HIGH: if (phase_end) begin
                    spi_clk <= 1'b0;
                    if (bit_cnt == BW'(DATA_WIDTH - 1)) begin
                        state <= TRAIL;
                    end else begin
                        tx_sh   <= tx_sh << 1;
                        mosi    <= tx_sh[DATA_WIDTH-2];
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= LOW;
                    end
                end
                TRAIL: if (phase_end) begin
                    cs_n    <= 1'b1;
                    mosi    <= 1'b0;
                    rx_data <= rx_sh;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed checks of spi_master at default and CLK_DIV=2/DATA_WIDTH=16 settings
module tb_spi_master;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  tx_data = 8'h00;
    logic        busy, done, spi_clk, cs_n, mosi, miso;
    logic [7:0]  rx_data;
    logic [1:0]  mode = 2'd2;
    logic        start2 = 1'b0;
    logic [15:0] tx2 = 16'h0000;
    logic        busy2, done2, spi_clk2, cs_n2, mosi2;
    logic [15:0] rx2;
    logic        clr = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          k;
    int          rises = 0, cs_falls = 0, dones = 0;
    logic [15:0] cap = '0;
    logic        sp_q, cs_q;
    int          rises2 = 0, cyc = 0, last_rise = 0, per2 = 0;
    logic        sp2_q;

    always #5 clk = ~clk;
    assign miso = mode == 2'd2 ? mosi : mode[0];

    spi_master dut (
        .clk(clk), .rst(rst), .start(start), .tx_data(tx_data), .busy(busy), .done(done),
        .rx_data(rx_data), .spi_clk(spi_clk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
    );
    spi_master #(.CLK_DIV(2), .DATA_WIDTH(16)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .tx_data(tx2), .busy(busy2), .done(done2),
        .rx_data(rx2), .spi_clk(spi_clk2), .cs_n(cs_n2), .mosi(mosi2), .miso(mosi2)
    );

    always @(posedge clk) begin
        if (clr) begin
            rises <= 0; cs_falls <= 0; dones <= 0; cap <= '0; rises2 <= 0; per2 <= 0;
        end else begin
            if (spi_clk && !sp_q) begin
                rises <= rises + 1;
                cap   <= {cap[14:0], mosi};
            end
            if (!cs_n && cs_q) cs_falls <= cs_falls + 1;
            if (done) dones <= dones + 1;
            if (spi_clk2 && !sp2_q) begin
                rises2    <= rises2 + 1;
                per2      <= cyc - last_rise;
                last_rise <= cyc;
            end
        end
        sp_q  <= spi_clk;
        cs_q  <= cs_n;
        sp2_q <= spi_clk2;
        cyc   <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); clr = 1'b0;
    endtask

    // Starts one transfer, optionally pulsing start (and scrambling tx_data) at cycles p1/p2.
    task automatic xfer(input logic [7:0] tx, input int p1, input int p2, output int n);
        @(negedge clk); tx_data = tx; start = 1'b1;
        @(negedge clk); start = 1'b0; n = 0;
        while (!done && n < 300) begin
            @(negedge clk); n++;
            start = (n == p1 || n == p2);
            if (start) tx_data = ~tx;
        end
        start = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_cs_n", cs_n, 1);
        check("reset_spi_clk", spi_clk, 0);
        check("reset_busy_done", {busy, done, mosi}, 0);
        check("reset_rx", rx_data, 0);
        rst = 1'b1;
        clear();

        mode = 2'd2;
        xfer(8'hA5, -1, -1, k);
        check("t1_latency", k, 68);
        check("t1_rx", rx_data, 8'hA5);
        check("t1_mosi_bits", cap[7:0], 8'hA5);
        check("t1_rises", rises, 8);
        @(negedge clk);
        check("t1_done_pulse", done, 0);

        clear();
        @(negedge clk); tx_data = 8'h77; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (29) @(negedge clk);
        check("t4_busy_before", busy, 1);
        rst = 1'b0;
        @(negedge clk);
        check("t4_spi_clk", spi_clk, 0);
        check("t4_cs_n", cs_n, 1);
        check("t4_busy", busy, 0);
        check("t4_rx", rx_data, 0);
        rst = 1'b1;
        repeat (80) @(negedge clk);
        check("t4_no_done", dones, 0);

        clear();
        mode = 2'd1;
        xfer(8'h00, -1, -1, k);
        check("t2_rx_ones", rx_data, 8'hFF);
        check("t2_rises_a", rises, 8);
        clear();
        mode = 2'd0;
        xfer(8'hFF, -1, -1, k);
        check("t2_rx_zeros", rx_data, 8'h00);
        check("t2_rises_b", rises, 8);

        clear();
        mode = 2'd2;
        xfer(8'h5A, 10, 40, k);
        check("t3_latency", k, 68);
        check("t3_rx", rx_data, 8'h5A);
        repeat (10) @(negedge clk);
        check("t3_single_done", dones, 1);
        check("t3_one_cs_window", cs_falls, 1);
        check("t3_idle", {busy, cs_n}, 2'b01);

        clear();
        @(negedge clk); tx_data = 8'h3C; start = 1'b1;
        @(negedge clk); k = 0;
        while (!done && k < 300) begin @(negedge clk); k++; end
        check("t5_first", k, 68);
        check("t5_rx_a", rx_data, 8'h3C);
        check("t5_cs_gap", cs_n, 1);
        @(negedge clk); k = 1;
        check("t5_cs_relow", cs_n, 0);
        while (!done && k < 300) begin @(negedge clk); k++; end
        start = 1'b0;
        check("t5_period", k, 69);
        check("t5_rx_b", rx_data, 8'h3C);
        repeat (80) @(negedge clk);
        check("t5_stop", {busy, cs_n}, 2'b01);

        clear();
        @(negedge clk); tx2 = 16'hBEEF; start2 = 1'b1;
        @(negedge clk); start2 = 1'b0; k = 0;
        while (!done2 && k < 300) begin @(negedge clk); k++; end
        check("t6_latency", k, 66);
        check("t6_rx", rx2, 16'hBEEF);
        check("t6_rises", rises2, 16);
        check("t6_period", per2, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
